// File: rtl/alu_mc_exec_if.sv
// Handshake bundle between the ALU decoder side (master) and the multi-cycle
// execute unit (slave).
interface alu_mc_exec_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;

  modport master (
    output flush, in_valid, alu_ctrl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  flush, in_valid, alu_ctrl, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/alu_mc_exec.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/compare, iterative
// one-bit-per-cycle shifts, result held until the downstream stage accepts it.
//
// state | meaning
// IDLE  | ready for a new op
// EXEC  | computing; shifts iterate here until cnt reaches zero
// DONE  | result valid, waiting for out_ready
module alu_mc_exec #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_mc_exec_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b10000;
  localparam logic [4:0] OP_AND  = 5'b00001;
  localparam logic [4:0] OP_OR   = 5'b00010;
  localparam logic [4:0] OP_XOR  = 5'b00011;
  localparam logic [4:0] OP_SLL  = 5'b00100;
  localparam logic [4:0] OP_SRL  = 5'b00101;
  localparam logic [4:0] OP_SRA  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b10111;
  localparam logic [4:0] OP_SLTU = 5'b11000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [4:0]       ctrl;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             is_shift;
  logic             in_shift;
  logic             accept;
  logic [WIDTH-1:0] alu_value;

  assign is_shift = (ctrl == OP_SLL) || (ctrl == OP_SRL) || (ctrl == OP_SRA);
  assign in_shift = (bus.alu_ctrl == OP_SLL) || (bus.alu_ctrl == OP_SRL) ||
                    (bus.alu_ctrl == OP_SRA);
  assign accept   = (state == IDLE) && bus.in_valid && !bus.flush;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) state_next = EXEC;
        EXEC: if (!is_shift || (cnt == '0)) state_next = DONE;
        DONE: if (bus.out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // handshake outputs
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
  end

  // shift ops have already done their work in acc, so they just pass it through
  always_comb begin
    alu_value = '0;
    case (ctrl)
      OP_ADD:  alu_value = acc + opb;
      OP_SUB:  alu_value = acc - opb;
      OP_AND:  alu_value = acc & opb;
      OP_OR:   alu_value = acc | opb;
      OP_XOR:  alu_value = acc ^ opb;
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_value = acc;
      OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(acc) < $signed(opb))};
      OP_SLTU: alu_value = {{(WIDTH-1){1'b0}}, (acc < opb)};
      default: alu_value = '0;
    endcase
  end

  // a flushed op never reaches result/zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl     <= '0;
      acc      <= '0;
      opb      <= '0;
      cnt      <= '0;
      result_r <= '0;
      zero_r   <= 1'b0;
    end else if (!bus.flush) begin
      if (accept) begin
        ctrl <= bus.alu_ctrl;
        acc  <= bus.a;
        opb  <= bus.b;
        cnt  <= in_shift ? bus.b[SHW-1:0] : '0;
      end else if (state == EXEC) begin
        if (is_shift && (cnt != '0)) begin
          case (ctrl)
            OP_SLL:  acc <= {acc[WIDTH-2:0], 1'b0};
            OP_SRL:  acc <= {1'b0, acc[WIDTH-1:1]};
            default: acc <= {acc[WIDTH-1], acc[WIDTH-1:1]};
          endcase
          cnt <= cnt - SHW'(1);
        end else begin
          result_r <= alu_value;
          zero_r   <= (alu_value == '0);
        end
      end
    end
  end

  assign bus.result = result_r;
  assign bus.zero   = zero_r;
endmodule

// File: tb/tb_alu_mc_exec.sv
// Bench for alu_mc_exec: directed cases, backpressure, flush, reset, and a
// random op stream checked against an arithmetic reference model.
module tb_alu_mc_exec;
  localparam int WIDTH = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_mc_exec_if #(.WIDTH(WIDTH)) bus ();

  alu_mc_exec #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] c, input logic [31:0] av,
                                        input logic [31:0] bv);
    int sh;
    sh = int'(bv % 32);
    case (c)
      5'b00000: return av + bv;
      5'b10000: return av - bv;
      5'b00001: return av & bv;
      5'b00010: return av | bv;
      5'b00011: return av ^ bv;
      5'b00100: return av << sh;
      5'b00101: return av >> sh;
      5'b00110: return 32'($signed(av) >>> sh);
      5'b10111: return ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
      5'b11000: return (av < bv) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int latency(input logic [4:0] c, input logic [31:0] bv);
    if (c == 5'b00100 || c == 5'b00101 || c == 5'b00110) return int'(bv % 32) + 1;
    return 1;
  endfunction

  // Present one op, then scramble the inputs; returns cycles from accept to out_valid.
  task automatic issue(input logic [4:0] c, input logic [31:0] av, input logic [31:0] bv,
                       output int cyc);
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = c;
    bus.a        = av;
    bus.b        = bv;
    tick();
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 5'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    cyc = 0;
    while (!bus.out_valid && cyc < WIDTH + 8) begin
      tick();
      cyc++;
    end
  endtask

  // Full op: issue, check latency/result/zero, release with (maybe random) out_ready.
  task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] av,
                        input logic [31:0] bv, input bit rand_ready);
    logic [31:0] exp;
    int          cyc;
    int          n;
    exp = model(c, av, bv);
    issue(c, av, bv, cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(latency(c, bv)));
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_zero"}, 32'(bus.zero), 32'(exp == 32'd0));
    n = 0;
    do begin
      bus.out_ready = rand_ready ? 1'($urandom) : 1'b1;
      tick();
      n++;
      if (!bus.in_ready) check({tag, "_held"}, bus.result, exp);
    end while (!bus.in_ready && n < 40);
    bus.out_ready = 1'b0;
    check({tag, "_release"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] av;
    logic [31:0] bv;
    logic [4:0]  c;
    logic [4:0]  codes [10];
    int          cyc;
    bit          saw_valid;

    codes = '{5'b00000, 5'b10000, 5'b00001, 5'b00010, 5'b00011,
              5'b00100, 5'b00101, 5'b00110, 5'b10111, 5'b11000};
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_ctrl  = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", bus.result, 32'd0);
    check("reset_zero", 32'(bus.zero), 32'd0);

    run_op("add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("sub_neg", 5'b10000, 32'd5, 32'd7, 1'b0);
    run_op("sra_31", 5'b00110, 32'h8000_0000, 32'd31, 1'b0);
    run_op("srl_31", 5'b00101, 32'h8000_0000, 32'd31, 1'b0);
    run_op("sll_hi_b", 5'b00100, 32'd1, 32'h25, 1'b0);
    run_op("sll_zero_amt", 5'b00100, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0);
    run_op("slt", 5'b10111, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("sltu", 5'b11000, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("undef", 5'b11111, 32'hDEAD_BEEF, 32'h1, 1'b0);
    run_op("and", 5'b00001, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    run_op("or", 5'b00010, 32'hF000_0001, 32'h0000_0F10, 1'b0);

    // backpressure: DONE holds while out_ready=0 and new ops are ignored
    issue(5'b00011, 32'hA5A5_0F0F, 32'h0F0F_A5A5, cyc);
    check("bp_latency", 32'(cyc), 32'd1);
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 5'b00000;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_result", bus.result, 32'hAAAA_AAAA);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("bp_no_accept", 32'(bus.busy), 32'd0);
    prev = 32'hAAAA_AAAA;

    // flush mid-shift
    issue(5'b00100, 32'd1, 32'd20, cyc);
    check("flush_pre_latency", 32'(cyc), 32'd21);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    prev = 32'h0010_0000;
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 5'b00100;
    bus.a        = 32'd1;
    bus.b        = 32'd20;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush_in_ready", 32'(bus.in_ready), 32'd1);
    check("flush_busy", 32'(bus.busy), 32'd0);
    check("flush_result_kept", bus.result, prev);
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("flush_no_out_valid", 32'(saw_valid), 32'd0);
    check("flush_result_final", bus.result, prev);

    // flush together with in_valid in IDLE: op not taken
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_idle_no_accept", 32'(bus.busy), 32'd0);

    // reset mid-shift
    bus.in_valid = 1'b1;
    bus.alu_ctrl = 5'b00110;
    bus.a        = 32'h8000_0000;
    bus.b        = 32'd31;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_result", bus.result, 32'd0);
    check("rst_mid_zero", 32'(bus.zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // random stream with random backpressure
    for (int i = 0; i < 100; i++) begin
      c  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : codes[$urandom_range(0, 9)];
      av = $urandom;
      bv = ($urandom_range(0, 3) == 0) ? av : $urandom;
      if ($urandom_range(0, 3) == 0) bv = bv & 32'h0000_0007;
      run_op("rand", c, av, bv, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
